mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Multi-cycle controller that shares the single asynchronous RAM_mem between the CPU instruction-fetch port and data port.
- Arbitrates the two requesters and sequences ce_n/oe_n/we_n with a programmable wait-state count.
- Drives the bidirectional data bus through an explicit output-enable; the top level owns the tri-state buffer.
- Rejects misaligned and out-of-window accesses without touching the RAM.

Parameters:
- START_ADDRESS, 32'h00000000, first byte address of the RAM window.
- MEMORY_SIZE, 2048, window size in bytes.
- WAIT_CYCLES, 2, cycles the we_n/oe_n strobe stays active (legal range 1..15).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request, held until i_ack.
- i_addr  in  32  instruction byte address.
- i_rdata  out  32  fetched word.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ack; access rejected.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_bw  in  1  byte-write qualifier (writes only).
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  valid with d_ack; access rejected.
- mem_ce_n / mem_oe_n / mem_we_n  out  1 each  RAM strobes, active-low.
- mem_bw  out  1  forwarded byte-write flag.
- mem_address  out  32  RAM address.
- mem_data_out  out  32  write data toward the RAM.
- mem_data_oe  out  1  1 = controller drives the data bus.
- mem_data_in  in  32  resolved data bus.
- busy  out  1  state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values, applied asynchronously (including in the middle of a transaction):
  - state = IDLE
  - ce_n = oe_n = we_n = 1
  - mem_data_oe = 0, mem_bw = 0
  - mem_address = 0, mem_data_out = 0
  - acks = 0, errs = 0
  - i_rdata = d_rdata = 0
  - last_grant = I
- States: IDLE, SETUP, ACCESS, HOLD, ACK.
- IDLE:
  - Strobes high, mem_data_oe = 0.
  - If any request is high, select a winner:
    - One requester high: that requester wins.
    - Both high: the port that is not last_grant wins (round-robin; after reset D wins first).
  - Latch the winner's address, we, bw, wdata; set last_grant to the winner.
  - Validity check on the latched request:
    - off = addr - START_ADDRESS must satisfy 0 <= off <= MEMORY_SIZE-4.
    - addr[1:0] must be 00 unless the request is a write with bw = 1.
    - Failure: go to ACK with err = 1. No strobe is asserted.
    - Pass: go to SETUP.
- SETUP (1 cycle):
  - ce_n = 0, address valid, we_n = 1.
  - Read: oe_n = 0. Write: mem_data_oe = 1.
- ACCESS (WAIT_CYCLES cycles, down-counter):
  - Read: oe_n = 0. On the edge ending the last cycle, capture mem_data_in into the owner's rdata. Next state ACK.
  - Write: we_n = 0, data driven. Next state HOLD.
- HOLD (write only, 1 cycle):
  - we_n = 1; ce_n, address and data stay stable. This keeps the asynchronous RAM from latching bus changes.
- ACK (1 cycle):
  - Strobes high, mem_data_oe = 0.
  - The owner's ack = 1; err as computed.
  - Next state IDLE. A new request can be granted on the following edge.
- Latency from the IDLE edge that samples req to ack high:
  - Read: WAIT_CYCLES + 2 cycles.
  - Write: WAIT_CYCLES + 3 cycles.
  - Error: 1 cycle.
- rdata holds its value until the same port completes another successful read. A write or an error leaves rdata unchanged.
- Request inputs are sampled only at grant. Changing or dropping req mid-transaction does not abort it; the ack still pulses.
- A request still high in the cycle after its ack starts a new transaction. A waiting requester is granted before any repeat from the same port.
- oe_n and we_n are never low in the same cycle.
- mem_data_oe = 1 only during SETUP, ACCESS and HOLD of a write.

Test Plan:
- Reset, then D read at 0x10 with RAM word 0x11223344, WAIT_CYCLES = 2 -> ce_n low 3 cycles, oe_n low 3 cycles; d_ack high exactly 4 cycles after the grant edge; d_rdata = 0x11223344; d_err = 0.
- D write 0xDEADBEEF to 0x20, then D read from 0x20 -> we_n low exactly 2 cycles, preceded and followed by a cycle with ce_n low and we_n high; readback = 0xDEADBEEF.
- i_req and d_req raised together, both held for 4 transactions -> grant order D, I, D, I; no cycle has both acks high.
- I read at 0x3 and at START_ADDRESS + MEMORY_SIZE -> i_ack one cycle after grant with i_err = 1; ce_n never low; i_rdata unchanged.
- D byte write (bw = 1) at 0x21 -> accepted with d_err = 0 and mem_bw = 1 during the access. A word write at 0x21 -> d_err = 1.
- reset_n pulsed low during write ACCESS -> same-cycle we_n = ce_n = 1 and mem_data_oe = 0; state IDLE; no ack issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter and strobe sequencer for a shared asynchronous RAM
module mem_arbiter #(
  parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
  parameter int          MEMORY_SIZE   = 2048,
  parameter int          WAIT_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_bw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_bw,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_data_oe,
  input  logic [31:0] mem_data_in,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

  // Owner / last-grant encoding: 0 = instruction port, 1 = data port.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [31:0] LAST_OFF  = 32'(MEMORY_SIZE - 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;

  logic        mem_ce_n_q, mem_ce_n_d;
  logic        mem_oe_n_q, mem_oe_n_d;
  logic        mem_we_n_q, mem_we_n_d;
  logic        mem_bw_q, mem_bw_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_out_q, mem_data_out_d;
  logic        mem_data_oe_q, mem_data_oe_d;
  logic        i_ack_q, i_ack_d;
  logic        i_err_q, i_err_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;

  logic        win_d;
  logic [31:0] win_addr;
  logic        win_we;
  logic        win_bw;
  logic [31:0] win_off;
  logic        win_ok;

  // Pick the winning requester (round-robin on contention) and pre-check its access.
  always_comb begin
    win_d    = d_req && (!i_req || (last_grant_q == PORT_I));
    win_addr = win_d ? d_addr : i_addr;
    win_we   = win_d && d_we;
    win_bw   = win_d && d_bw;
    // Unsigned wrap makes addresses below the window look huge, so one compare covers both ends.
    win_off  = win_addr - START_ADDRESS;
    win_ok   = (win_off <= LAST_OFF) &&
               ((win_addr[1:0] == 2'b00) || (win_we && win_bw));
  end

  // Next-state and next-output logic; every output is the registered copy of its _d value.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    we_d           = we_q;
    mem_ce_n_d     = mem_ce_n_q;
    mem_oe_n_d     = mem_oe_n_q;
    mem_we_n_d     = mem_we_n_q;
    mem_bw_d       = mem_bw_q;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    mem_data_oe_d  = mem_data_oe_q;
    i_ack_d        = 1'b0;
    i_err_d        = 1'b0;
    d_ack_d        = 1'b0;
    d_err_d        = 1'b0;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        mem_ce_n_d    = 1'b1;
        mem_oe_n_d    = 1'b1;
        mem_we_n_d    = 1'b1;
        mem_data_oe_d = 1'b0;
        if (i_req || d_req) begin
          owner_d       = win_d;
          last_grant_d  = win_d;
          we_d          = win_we;
          mem_address_d = win_addr;
          mem_bw_d      = win_we && win_bw;
          if (win_we) begin
            mem_data_out_d = d_wdata;
          end
          if (win_ok) begin
            state_d       = ST_SETUP;
            mem_ce_n_d    = 1'b0;
            mem_oe_n_d    = win_we;
            mem_data_oe_d = win_we;
          end else begin
            state_d = ST_ACK;
            if (win_d == PORT_D) begin
              d_ack_d = 1'b1;
              d_err_d = 1'b1;
            end else begin
              i_ack_d = 1'b1;
              i_err_d = 1'b1;
            end
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = WAIT_INIT;
        if (we_q) begin
          mem_we_n_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q <= 4'd1) begin
          if (we_q) begin
            // Release we_n first while ce_n, address and data stay put.
            state_d    = ST_HOLD;
            mem_we_n_d = 1'b1;
          end else begin
            state_d    = ST_ACK;
            mem_ce_n_d = 1'b1;
            mem_oe_n_d = 1'b1;
            if (owner_q == PORT_D) begin
              d_rdata_d = mem_data_in;
              d_ack_d   = 1'b1;
            end else begin
              i_rdata_d = mem_data_in;
              i_ack_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_HOLD: begin
        state_d       = ST_ACK;
        mem_ce_n_d    = 1'b1;
        mem_data_oe_d = 1'b0;
        if (owner_q == PORT_D) begin
          d_ack_d = 1'b1;
        end else begin
          i_ack_d = 1'b1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d       = ST_IDLE;
        mem_ce_n_d    = 1'b1;
        mem_oe_n_d    = 1'b1;
        mem_we_n_d    = 1'b1;
        mem_data_oe_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset forces the RAM strobes inactive immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      owner_q        <= PORT_I;
      last_grant_q   <= PORT_I;
      we_q           <= 1'b0;
      mem_ce_n_q     <= 1'b1;
      mem_oe_n_q     <= 1'b1;
      mem_we_n_q     <= 1'b1;
      mem_bw_q       <= 1'b0;
      mem_address_q  <= 32'd0;
      mem_data_out_q <= 32'd0;
      mem_data_oe_q  <= 1'b0;
      i_ack_q        <= 1'b0;
      i_err_q        <= 1'b0;
      d_ack_q        <= 1'b0;
      d_err_q        <= 1'b0;
      i_rdata_q      <= 32'd0;
      d_rdata_q      <= 32'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      we_q           <= we_d;
      mem_ce_n_q     <= mem_ce_n_d;
      mem_oe_n_q     <= mem_oe_n_d;
      mem_we_n_q     <= mem_we_n_d;
      mem_bw_q       <= mem_bw_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      mem_data_oe_q  <= mem_data_oe_d;
      i_ack_q        <= i_ack_d;
      i_err_q        <= i_err_d;
      d_ack_q        <= d_ack_d;
      d_err_q        <= d_err_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      busy_q         <= busy_d;
    end
  end

  assign mem_ce_n     = mem_ce_n_q;
  assign mem_oe_n     = mem_oe_n_q;
  assign mem_we_n     = mem_we_n_q;
  assign mem_bw       = mem_bw_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_data_oe  = mem_data_oe_q;
  assign i_ack        = i_ack_q;
  assign i_err        = i_err_q;
  assign d_ack        = d_ack_q;
  assign d_err        = d_err_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with an asynchronous RAM model
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic        d_bw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        mem_bw;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic        mem_data_oe;
  logic [31:0] mem_data_in;
  logic        busy;

  mem_arbiter #(
    .START_ADDRESS(32'h0000_0000),
    .MEMORY_SIZE  (2048),
    .WAIT_CYCLES  (W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ack       (i_ack),
    .i_err       (i_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_bw        (d_bw),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .d_err       (d_err),
    .mem_ce_n    (mem_ce_n),
    .mem_oe_n    (mem_oe_n),
    .mem_we_n    (mem_we_n),
    .mem_bw      (mem_bw),
    .mem_address (mem_address),
    .mem_data_out(mem_data_out),
    .mem_data_oe (mem_data_oe),
    .mem_data_in (mem_data_in),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  logic [31:0] ram    [512];
  logic [31:0] shadow [512];

  // Asynchronous RAM: reads while ce_n/oe_n are low, word writes latch on the rising we_n.
  assign mem_data_in = (!mem_ce_n && !mem_oe_n) ? ram[mem_address[10:2]] : 32'h0;

  always @(posedge mem_we_n) begin
    if (!mem_ce_n && !mem_bw) ram[mem_address[10:2]] = mem_data_out;
  end

  typedef struct {
    bit          port_d;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          overlap_cnt = 0;
  int          both_ack_cnt = 0;
  logic [31:0] mdl_i_rdata = 32'h0;
  logic [31:0] mdl_d_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every ack pops the oldest expectation.
  always @(negedge clock) begin
    if (reset_n) begin
      if (!mem_oe_n && !mem_we_n) overlap_cnt++;
      if (i_ack && d_ack) both_ack_cnt++;
      if (i_ack || d_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_port", 32'(d_ack), 32'(e.port_d));
          if (e.port_d) begin
            check("d_err", 32'(d_err), 32'(e.err));
            check("d_rdata", d_rdata, e.rdata);
          end else begin
            check("i_err", 32'(i_err), 32'(e.err));
            check("i_rdata", i_rdata, e.rdata);
          end
        end
      end
    end
  end

  function automatic exp_t make_exp(input bit port_d, input bit we, input bit bw,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input bit exp_err);
    exp_t e;
    logic [8:0] idx;
    idx = addr[10:2];
    e.port_d = port_d;
    e.err    = exp_err;
    if (!exp_err && !we) begin
      if (port_d) mdl_d_rdata = shadow[idx];
      else        mdl_i_rdata = shadow[idx];
    end
    if (!exp_err && we && !bw) shadow[idx] = wdata;
    e.rdata = port_d ? mdl_d_rdata : mdl_i_rdata;
    return e;
  endfunction

  // One isolated transaction, started from a known idle cycle, with strobe-shape checks.
  task automatic run_txn(input string tag, input bit port_d, input bit we, input bit bw,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit exp_err);
    int lat, ce_cnt, oe_cnt, we_cnt, doe_cnt;
    bit done, bw_seen, first_we, last_we;
    sb.push_back(make_exp(port_d, we, bw, addr, wdata, exp_err));
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_bw = bw; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    lat = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
    done = 1'b0; bw_seen = 1'b0; first_we = 1'b0; last_we = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      if (!mem_ce_n) begin
        if (ce_cnt == 0) first_we = mem_we_n;
        last_we = mem_we_n;
        ce_cnt++;
      end
      if (!mem_oe_n) oe_cnt++;
      if (!mem_we_n) begin
        we_cnt++;
        if (mem_bw) bw_seen = 1'b1;
      end
      if (mem_data_oe) doe_cnt++;
      if (port_d ? d_ack : i_ack) done = 1'b1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_latency"}, lat, exp_err ? 1 : (we ? W + 3 : W + 2));
    check({tag, "_ce_cycles"}, ce_cnt, exp_err ? 0 : (we ? W + 2 : W + 1));
    check({tag, "_oe_cycles"}, oe_cnt, (exp_err || we) ? 0 : W + 1);
    check({tag, "_we_cycles"}, we_cnt, (!exp_err && we) ? W : 0);
    check({tag, "_doe_cycles"}, doe_cnt, (!exp_err && we) ? W + 2 : 0);
    if (!exp_err && we) begin
      check({tag, "_we_setup_high"}, 32'(first_we), 32'(1));
      check({tag, "_we_hold_high"}, 32'(last_we), 32'(1));
      if (bw) check({tag, "_mem_bw"}, 32'(bw_seen), 32'(1));
    end
    @(negedge clock);
  endtask

  initial begin
    int acks;
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_bw = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 512; i++) begin
      ram[i]    = {16'hC0DE, 16'(i)};
      shadow[i] = {16'hC0DE, 16'(i)};
    end
    ram[4]    = 32'h1122_3344;
    shadow[4] = 32'h1122_3344;

    repeat (3) @(negedge clock);
    check("rst_ce_n", 32'(mem_ce_n), 32'(1));
    check("rst_oe_n", 32'(mem_oe_n), 32'(1));
    check("rst_we_n", 32'(mem_we_n), 32'(1));
    check("rst_data_oe", 32'(mem_data_oe), 32'(0));
    check("rst_acks", {30'd0, i_ack, d_ack}, 32'(0));
    check("rst_address", mem_address, 32'h0);
    check("rst_rdata", i_rdata | d_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'(0));
    reset_n = 1'b1;
    @(negedge clock);

    run_txn("d_rd_10",   1'b1, 1'b0, 1'b0, 32'h10,  32'h0,         1'b0);
    run_txn("d_wr_20",   1'b1, 1'b1, 1'b0, 32'h20,  32'hDEAD_BEEF, 1'b0);
    run_txn("d_rd_20",   1'b1, 1'b0, 1'b0, 32'h20,  32'h0,         1'b0);
    run_txn("i_rd_08",   1'b0, 1'b0, 1'b0, 32'h08,  32'h0,         1'b0);
    run_txn("i_rd_03",   1'b0, 1'b0, 1'b0, 32'h03,  32'h0,         1'b1);
    run_txn("i_rd_800",  1'b0, 1'b0, 1'b0, 32'h800, 32'h0,         1'b1);
    check("i_rdata_kept", i_rdata, shadow[2]);
    run_txn("i_rd_7fc",  1'b0, 1'b0, 1'b0, 32'h7FC, 32'h0,         1'b0);
    run_txn("d_bwr_21",  1'b1, 1'b1, 1'b1, 32'h21,  32'h0000_00AB, 1'b0);
    run_txn("d_wwr_21",  1'b1, 1'b1, 1'b0, 32'h21,  32'h5555_AAAA, 1'b1);
    run_txn("d_rd_20b",  1'b1, 1'b0, 1'b0, 32'h20,  32'h0,         1'b0);

    // Reset asserted in the middle of a write strobe.
    d_req = 1'b1; d_we = 1'b1; d_bw = 1'b0; d_addr = 32'h30; d_wdata = 32'h1234_5678;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_we_n", 32'(mem_we_n), 32'(0));
    #1 reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    check("mid_rst_we_n", 32'(mem_we_n), 32'(1));
    check("mid_rst_ce_n", 32'(mem_ce_n), 32'(1));
    check("mid_rst_data_oe", 32'(mem_data_oe), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    mdl_i_rdata = 32'h0;
    mdl_d_rdata = 32'h0;
    acks = 0;
    repeat (8) begin
      @(negedge clock);
      if (i_ack || d_ack) acks++;
    end
    check("post_rst_no_ack", acks, 0);

    // Both ports held: round-robin must alternate starting with D after reset.
    sb.push_back(make_exp(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0));
    sb.push_back(make_exp(1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 1'b0));
    sb.push_back(make_exp(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0));
    sb.push_back(make_exp(1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 1'b0));
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_bw = 1'b0; d_addr = 32'h40;
    acks = 0;
    for (int c = 0; c < 100 && acks < 4; c++) begin
      @(negedge clock);
      if (i_ack || d_ack) acks++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("rr_ack_count", acks, 4);
    repeat (3) @(negedge clock);

    check("oe_we_overlap", overlap_cnt, 0);
    check("both_acks", both_ack_cnt, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
